// File: rtl/ram_mm2s_reader_pkg.sv
// Shared types for the mm2s RAM reader: FSM states and the FIFO beat record.
package ram_mm2s_pkg;

  // Data width the beat record is built for; the top's AXI_WIDTH must match.
  localparam int AXI_WIDTH_DEF = 128;

  // Byte-to-word shift for a word of w bits.
  function automatic int lsb_of(input int w);
    return $clog2(w) - 3;
  endfunction

  localparam int LSB_DEF = lsb_of(AXI_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // One returned word plus its end-of-command tag.
  typedef struct packed {
    logic [AXI_WIDTH_DEF-1:0] data;
    logic                     last;
  } beat_t;

endpackage

// File: rtl/ram_mm2s_reader_if.sv
// Command, RAM read port and output stream of one mm2s reader channel.
interface ram_mm2s_reader_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int LSB            = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr;
  logic [LEN_WIDTH-1:0]          cmd_len;
  logic                          mm2s_ren;
  logic [AXI_ADDR_WIDTH-LSB-1:0] mm2s_addr;
  logic [AXI_WIDTH-1:0]          mm2s_data;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic [AXI_WIDTH-1:0]          m_axis_tdata;
  logic                          m_axis_tlast;
  logic                          done;

  // Reader side.
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mm2s_data, m_axis_tready,
    output cmd_ready, mm2s_ren, mm2s_addr, m_axis_tvalid, m_axis_tdata,
           m_axis_tlast, done
  );

  // Environment side: command source, RAM and stream sink.
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mm2s_data, m_axis_tready,
    input  cmd_ready, mm2s_ren, mm2s_addr, m_axis_tvalid, m_axis_tdata,
           m_axis_tlast, done
  );
endinterface

// File: rtl/ram_mm2s_reader_fifo.sv
// First-word-fall-through return buffer; head is visible whenever not empty.
module sync_fifo_fwft
  import ram_mm2s_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  beat_t         push_beat_i,
  input  logic          pop_i,
  output beat_t         head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  beat_t         mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A pop frees the head slot in the same cycle, so push into a full FIFO is fine then.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_beat_i;
        wptr_q        <= nxt(wptr_q);
      end
      if (pop_ok) rptr_q <= nxt(rptr_q);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ram_mm2s_reader.sv
// mm2s reader: turns {byte address, beat count} into a gap-free AXI-Stream,
// issuing RAM reads only when a return slot is guaranteed.
module ram_mm2s_reader
  import ram_mm2s_pkg::*;
#(
  parameter  int AXI_WIDTH      = AXI_WIDTH_DEF,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int LEN_WIDTH      = 16,
  parameter  int DEPTH          = 2,
  localparam int LSB            = lsb_of(AXI_WIDTH),
  localparam int WAW            = AXI_ADDR_WIDTH - LSB,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rstn,
  ram_mm2s_reader_if.master bus
);
  state_t               state_q, state_d;
  logic [WAW-1:0]       waddr_q, waddr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 infl_q, last_q;
  logic                 ren, pop, cmd_ready;
  logic                 fifo_empty, fifo_full;
  logic [CW-1:0]        fifo_cnt;
  logic [CW:0]          occ;
  beat_t                head, push_beat;

  // Slots committed after this cycle if nothing new issues.
  assign pop = bus.m_axis_tvalid && bus.m_axis_tready;
  assign occ = {1'b0, fifo_cnt} + (CW+1)'(infl_q) - (CW+1)'(pop);
  assign ren = (state_q == READ) && (rem_q != '0) && (occ < (CW+1)'(DEPTH))
            && (!fifo_full || pop);

  // Next state, address counter and remaining-beat counter.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          waddr_d = WAW'(bus.cmd_addr >> LSB);
          rem_d   = bus.cmd_len;
          state_d = (bus.cmd_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (ren) begin
          waddr_d = waddr_q + WAW'(1);
          rem_d   = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      // Leave once nothing is in flight and the last buffered beat is handshaking.
      DRAIN: begin
        if (!infl_q && (fifo_empty || (fifo_cnt == CW'(1) && pop))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and the 1-cycle read-latency tracker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      waddr_q <= '0;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
      infl_q  <= ren;
      last_q  <= ren && (rem_q == LEN_WIDTH'(1));
    end
  end

  assign push_beat = '{data: bus.mm2s_data, last: last_q};

  sync_fifo_fwft #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (infl_q),
    .push_beat_i(push_beat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign bus.cmd_ready     = cmd_ready;
  assign bus.mm2s_ren      = ren;
  assign bus.mm2s_addr     = waddr_q;
  assign bus.m_axis_tvalid = !fifo_empty;
  assign bus.m_axis_tdata  = head.data;
  assign bus.m_axis_tlast  = head.last && !fifo_empty;
  assign bus.done          = (state_q == DONE);
endmodule

// File: tb/tb_ram_mm2s_reader.sv
// Directed bench for ram_mm2s_reader with a RAM model and stream scoreboard.
module tb_ram_mm2s_reader;
  localparam int W  = 128;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int D  = 2;
  localparam int L  = 4;
  localparam int WA = AW - L;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ram_mm2s_reader_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .LSB(L)) bus ();

  ram_mm2s_reader #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DEPTH(D)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [WA-1:0] addr_q[$];
  logic busy, done_exp, prev_stall, prev_last;
  logic [W-1:0] prev_data;
  int   issued, popped, hs_total, cyc, cmd_beats, first_cyc, span;
  logic tready_fix, rand_mode;

  function automatic logic [W-1:0] memf(input logic [WA-1:0] wa);
    logic [31:0] a;
    a = {4'h0, wa};
    return {a ^ 32'hDEAD_BEEF, ~a, {a[27:0], 4'h5} ^ 32'h1234_5678, 32'hC0DE_0000 + a};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM: one-cycle read latency, junk on the data bus when not reading.
  always @(posedge clk)
    bus.mm2s_data <= bus.mm2s_ren ? memf(bus.mm2s_addr) : {4{$urandom}};

  // Stream sink ready: fixed level or 50% random.
  always @(posedge clk) begin
    #1;
    bus.m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_fix;
  end

  // Monitor: commands, read addresses, credit bound, beats, stability, done.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete(); addr_q.delete();
      busy = 0; done_exp = 0; prev_stall = 0;
      issued = 0; popped = 0;
    end else begin
      cyc++;
      check("done", W'(bus.done), W'(done_exp));
      if (bus.done) busy = 0;
      done_exp = 0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        check("accept_when_idle", W'(busy), W'(0));
        busy = 1; cmd_beats = 0;
        for (int i = 0; i < int'(bus.cmd_len); i++) begin
          logic [WA-1:0] wa;
          wa = WA'(bus.cmd_addr >> L) + WA'(i);
          addr_q.push_back(wa);
          sb.push_back('{d: memf(wa), l: (i == int'(bus.cmd_len) - 1)});
        end
        if (bus.cmd_len == '0) done_exp = 1;
      end
      if (bus.mm2s_ren) begin
        if (addr_q.size() == 0) check("spurious_ren", W'(1), W'(0));
        else check("mm2s_addr", W'(bus.mm2s_addr), W'(addr_q.pop_front()));
        issued++;
      end
      if (prev_stall) begin
        check("stall_tvalid", W'(bus.m_axis_tvalid), W'(1));
        check("stall_tdata", bus.m_axis_tdata, prev_data);
        check("stall_tlast", W'(bus.m_axis_tlast), W'(prev_last));
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
      prev_last  = bus.m_axis_tlast;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        popped++; hs_total++;
        if (sb.size() == 0) check("spurious_beat", W'(1), W'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          check("tdata", bus.m_axis_tdata, e.d);
          check("tlast", W'(bus.m_axis_tlast), W'(e.l));
          if (cmd_beats == 0) first_cyc = cyc;
          cmd_beats++;
          if (e.l) begin
            span = cyc - first_cyc;
            done_exp = 1;
          end
        end
      end
      check("credit", W'((issued - popped) <= D), W'(1));
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] n);
    int k;
    bus.cmd_valid = 1; bus.cmd_addr = a; bus.cmd_len = n;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.cmd_ready && k < 2000);
    check("cmd_accept_timeout", W'(bus.cmd_ready), W'(1));
    @(posedge clk); #1;
    bus.cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 3000) begin @(posedge clk); #1; k++; end
    check("idle_timeout", W'(busy || sb.size() != 0), W'(0));
  endtask

  task automatic wait_beats(input int target);
    int k;
    k = 0;
    while (hs_total < target && k < 1000) begin @(posedge clk); #1; k++; end
    check("beat_timeout", W'(hs_total >= target), W'(1));
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_cmd_ready"}, W'(bus.cmd_ready), W'(1));
    check({p, "_ren"}, W'(bus.mm2s_ren), W'(0));
    check({p, "_addr"}, W'(bus.mm2s_addr), W'(0));
    check({p, "_tvalid"}, W'(bus.m_axis_tvalid), W'(0));
    check({p, "_tlast"}, W'(bus.m_axis_tlast), W'(0));
    check({p, "_tdata"}, bus.m_axis_tdata, W'(0));
    check({p, "_done"}, W'(bus.done), W'(0));
  endtask

  initial begin
    int base, iss0;
    rstn = 0; bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.m_axis_tready = 1; tready_fix = 1; rand_mode = 0;
    hs_total = 0; cyc = 0; cmd_beats = 0; first_cyc = 0; span = -1;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("rst");
    rstn = 1;
    repeat (2) @(posedge clk); #1;

    // 4 beats, tready high: back-to-back beats, done right after the last.
    send(32'h0000_1000, 4);
    wait_idle();
    check("t1_beats", W'(cmd_beats), W'(4));
    check("t1_span", W'(span), W'(3));

    // 8 beats with a 10-cycle sink stall after beat 2.
    base = hs_total;
    send(32'h0000_2000, 8);
    wait_beats(base + 2);
    tready_fix = 0;
    repeat (10) @(posedge clk); #1;
    tready_fix = 1;
    wait_idle();
    check("t2_beats", W'(hs_total - base), W'(8));

    // Zero-length command: no reads, no beats, done only.
    base = hs_total; iss0 = issued;
    send(32'h0000_3000, 0);
    wait_idle();
    check("t3_beats", W'(hs_total - base), W'(0));
    check("t3_reads", W'(issued - iss0), W'(0));

    // Word address wraps to zero.
    base = hs_total;
    send(32'hFFFF_FFE0, 3);
    wait_idle();
    check("t4_beats", W'(hs_total - base), W'(3));

    // Random backpressure, second command held behind the first.
    base = hs_total;
    rand_mode = 1;
    send(32'h0000_4000, 32);
    send(32'h0000_5010, 5);
    wait_idle();
    rand_mode = 0;
    check("t5_beats", W'(hs_total - base), W'(37));

    // Reset in the middle of a 10-beat command, then a clean 2-beat command.
    base = hs_total;
    send(32'h0000_6000, 10);
    wait_beats(base + 3);
    #2 rstn = 0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk); #1;
    rstn = 1;
    repeat (2) @(posedge clk); #1;
    base = hs_total;
    send(32'h0000_7000, 2);
    wait_idle();
    check("t6_beats", W'(hs_total - base), W'(2));
    repeat (5) @(posedge clk); #1;
    check("t6_no_extra", W'(hs_total - base), W'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
